// File: rtl/exu_branch_resolve_unit.sv
// EXU branch resolution stage: resolves JAL/JALR/B-type, detects direction/target mispredicts,
// redirects fetch, strobes branch-predictor updates and keeps saturating perf counters.
module exu_branch_resolve_unit #(
  parameter int              XLEN            = 32,
  parameter logic [XLEN-1:0] PC_INIT         = '0,
  parameter bit              PRED_TARGET_CHK = 1'b1,
  parameter int              FLUSH_SHADOW    = 2,
  parameter int              CNT_W           = 16
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             i_stall,
  input  logic [XLEN-1:0]  i_pc,
  input  logic             i_bubble,
  input  logic             i_is_jal,
  input  logic             i_is_jalr,
  input  logic             i_is_b_type,
  input  logic [2:0]       i_funct3,
  input  logic [11:0]      i_immI,
  input  logic [11:0]      i_immB,
  input  logic [XLEN-1:0]  i_op0,
  input  logic [XLEN-1:0]  i_op1,
  input  logic             i_op0_lt_op1,
  input  logic             i_sign_op0_lt_op1,
  input  logic             i_pred_taken,
  input  logic [XLEN-1:0]  i_pred_pc,
  input  logic             i_cnt_clr,
  output logic [XLEN-1:0]  o_nxt_instr_pc,
  output logic             o_bubble,
  output logic             o_branch_taken,
  output logic [XLEN-1:0]  o_branch_pc,
  output logic             o_flush,
  output logic             o_bp_upd_valid,
  output logic [XLEN-1:0]  o_bp_upd_pc,
  output logic             o_bp_upd_taken,
  output logic [XLEN-1:0]  o_bp_upd_target,
  output logic [CNT_W-1:0] o_cnt_branches,
  output logic [CNT_W-1:0] o_cnt_mispredicts
);

  logic            sel_jalr, sel_jal, sel_b, b_legal;
  logic            op_eq, b_cond, res_taken, res_mis, cap_valid;
  logic [XLEN-1:0] imm_i_sext, imm_b_sext, pc_plus4, res_target;
  logic [2:0]      shadow_eff;
  logic            retire, flush;

  logic            valid_q, valid_d;
  logic            mis_q, mis_d;
  logic            jump_q, jump_d;
  logic            taken_q, taken_d;
  logic [XLEN-1:0] target_q, target_d;
  logic [XLEN-1:0] nxt_pc_q, nxt_pc_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [2:0]      shadow_q, shadow_d;
  logic [CNT_W-1:0] cnt_br_q, cnt_br_d;
  logic [CNT_W-1:0] cnt_mis_q, cnt_mis_d;

  assign flush  = valid_q & mis_q;
  assign retire = valid_q & ~i_stall;

  always_comb begin
    sel_jalr   = i_is_jalr;
    sel_jal    = ~i_is_jalr & i_is_jal;
    sel_b      = ~i_is_jalr & ~i_is_jal & i_is_b_type;
    b_legal    = sel_b & (i_funct3[2:1] != 2'b01);
    op_eq      = (i_op0 == i_op1);
    imm_i_sext = {{(XLEN-12){i_immI[11]}}, i_immI};
    imm_b_sext = {{(XLEN-13){i_immB[11]}}, i_immB, 1'b0};
    pc_plus4   = i_pc + XLEN'(4);

    case (i_funct3)
      3'b000:  b_cond = op_eq;
      3'b001:  b_cond = ~op_eq;
      3'b100:  b_cond = i_sign_op0_lt_op1;
      3'b101:  b_cond = ~i_sign_op0_lt_op1;
      3'b110:  b_cond = i_op0_lt_op1;
      3'b111:  b_cond = ~i_op0_lt_op1;
      default: b_cond = 1'b0;
    endcase

    res_taken = sel_jalr | sel_jal | (b_legal & b_cond);

    if (sel_jalr)
      res_target = (i_op0 + imm_i_sext) & ~XLEN'(1);
    else if (sel_jal)
      res_target = i_pred_pc;
    else if (b_legal & b_cond)
      res_target = i_pc + imm_b_sext;
    else
      res_target = pc_plus4;

    res_mis = (res_taken != i_pred_taken) |
              (PRED_TARGET_CHK & res_taken & (res_target != i_pred_pc));

    // The capture that coincides with a flush is already the first wrong-path slot,
    // so the shadow window starts counting from that edge.
    shadow_eff = flush ? 3'(FLUSH_SHADOW) : shadow_q;
    cap_valid  = ~i_bubble & (sel_jal | sel_jalr | b_legal) & (shadow_eff == 3'd0);
  end

  always_comb begin
    valid_d  = valid_q;
    mis_d    = mis_q;
    jump_d   = jump_q;
    taken_d  = taken_q;
    target_d = target_q;
    nxt_pc_d = nxt_pc_q;
    pc_d     = pc_q;
    shadow_d = shadow_q;
    if (!i_stall) begin
      valid_d  = cap_valid;
      mis_d    = res_mis;
      jump_d   = sel_jal | sel_jalr;
      taken_d  = res_taken;
      target_d = res_target;
      nxt_pc_d = pc_plus4;
      pc_d     = i_pc;
      shadow_d = (shadow_eff != 3'd0) ? shadow_eff - 3'd1 : 3'd0;
    end

    // Clear wins over a coincident retire; both counters stick at all-ones.
    cnt_br_d  = cnt_br_q;
    cnt_mis_d = cnt_mis_q;
    if (i_cnt_clr) begin
      cnt_br_d  = '0;
      cnt_mis_d = '0;
    end else if (retire) begin
      if (cnt_br_q != '1)
        cnt_br_d = cnt_br_q + CNT_W'(1);
      if (flush && cnt_mis_q != '1)
        cnt_mis_d = cnt_mis_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      valid_q   <= 1'b0;
      mis_q     <= 1'b0;
      jump_q    <= 1'b0;
      taken_q   <= 1'b0;
      target_q  <= PC_INIT;
      nxt_pc_q  <= PC_INIT;
      pc_q      <= PC_INIT;
      shadow_q  <= 3'd0;
      cnt_br_q  <= '0;
      cnt_mis_q <= '0;
    end else begin
      valid_q   <= valid_d;
      mis_q     <= mis_d;
      jump_q    <= jump_d;
      taken_q   <= taken_d;
      target_q  <= target_d;
      nxt_pc_q  <= nxt_pc_d;
      pc_q      <= pc_d;
      shadow_q  <= shadow_d;
      cnt_br_q  <= cnt_br_d;
      cnt_mis_q <= cnt_mis_d;
    end
  end

  assign o_nxt_instr_pc    = nxt_pc_q;
  assign o_bubble          = ~(valid_q & jump_q);
  assign o_branch_taken    = taken_q;
  assign o_branch_pc       = target_q;
  assign o_flush           = flush;
  assign o_bp_upd_valid    = retire;
  assign o_bp_upd_pc       = pc_q;
  assign o_bp_upd_taken    = taken_q;
  assign o_bp_upd_target   = target_q;
  assign o_cnt_branches    = cnt_br_q;
  assign o_cnt_mispredicts = cnt_mis_q;

endmodule

// File: tb/tb_exu_branch_resolve_unit.sv
// Randomised scoreboard bench for exu_branch_resolve_unit: the driver predicts each slot's
// retire record from the ISA rules, the monitor pops and compares on every predictor update.
module tb_exu_branch_resolve_unit;

  localparam int          XLEN         = 32;
  localparam logic [31:0] PC_INIT      = 32'h0000_0080;
  localparam int          FLUSH_SHADOW = 2;
  localparam int          CNT_W        = 4;
  localparam int          CNT_MAX      = (1 << CNT_W) - 1;

  logic clk, aresetn, i_stall, i_bubble, i_is_jal, i_is_jalr, i_is_b_type;
  logic [2:0]  i_funct3;
  logic [11:0] i_immI, i_immB;
  logic [31:0] i_pc, i_op0, i_op1, i_pred_pc;
  logic i_op0_lt_op1, i_sign_op0_lt_op1, i_pred_taken, i_cnt_clr;
  logic [31:0] o_nxt_instr_pc, o_branch_pc, o_bp_upd_pc, o_bp_upd_target;
  logic o_bubble, o_branch_taken, o_flush, o_bp_upd_valid, o_bp_upd_taken;
  logic [CNT_W-1:0] o_cnt_branches, o_cnt_mispredicts;

  exu_branch_resolve_unit #(
    .XLEN(XLEN), .PC_INIT(PC_INIT), .PRED_TARGET_CHK(1'b1),
    .FLUSH_SHADOW(FLUSH_SHADOW), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .aresetn(aresetn), .i_stall(i_stall), .i_pc(i_pc), .i_bubble(i_bubble),
    .i_is_jal(i_is_jal), .i_is_jalr(i_is_jalr), .i_is_b_type(i_is_b_type),
    .i_funct3(i_funct3), .i_immI(i_immI), .i_immB(i_immB), .i_op0(i_op0), .i_op1(i_op1),
    .i_op0_lt_op1(i_op0_lt_op1), .i_sign_op0_lt_op1(i_sign_op0_lt_op1),
    .i_pred_taken(i_pred_taken), .i_pred_pc(i_pred_pc), .i_cnt_clr(i_cnt_clr),
    .o_nxt_instr_pc(o_nxt_instr_pc), .o_bubble(o_bubble), .o_branch_taken(o_branch_taken),
    .o_branch_pc(o_branch_pc), .o_flush(o_flush), .o_bp_upd_valid(o_bp_upd_valid),
    .o_bp_upd_pc(o_bp_upd_pc), .o_bp_upd_taken(o_bp_upd_taken),
    .o_bp_upd_target(o_bp_upd_target), .o_cnt_branches(o_cnt_branches),
    .o_cnt_mispredicts(o_cnt_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, target, nxt;
    logic        taken, flush, jump;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_fail = 0;

  // Slot currently being prepared by the driver.
  bit          s_bubble, s_jal, s_jalr, s_b, s_pt;
  logic [2:0]  s_f3;
  logic [11:0] s_ii, s_ib;
  logic [31:0] s_pc, s_op0, s_op1, s_ppc;

  // Reference state: wrong-path slots still to be discarded, and whether the slot
  // now sitting in the stage will redirect fetch.
  int wrong_path_left = 0;
  bit pending_redirect = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_slot(input bit bub, input bit jal, input bit jalr, input bit b,
                          input logic [2:0] f3, input logic [11:0] ii, input logic [11:0] ib,
                          input logic [31:0] pc, input logic [31:0] op0, input logic [31:0] op1,
                          input bit pt, input logic [31:0] ppc);
    s_bubble = bub; s_jal = jal; s_jalr = jalr; s_b = b; s_f3 = f3; s_ii = ii; s_ib = ib;
    s_pc = pc; s_op0 = op0; s_op1 = op1; s_pt = pt; s_ppc = ppc;
  endtask

  task automatic issue(input bit stall, input bit clr);
    bit ctl, tk, mis, ok;
    int remaining;
    logic [31:0] tgt, si, sb;
    exp_t r;
    i_stall = stall; i_cnt_clr = clr;
    i_bubble = s_bubble; i_is_jal = s_jal; i_is_jalr = s_jalr; i_is_b_type = s_b;
    i_funct3 = s_f3; i_immI = s_ii; i_immB = s_ib; i_pc = s_pc;
    i_op0 = s_op0; i_op1 = s_op1; i_pred_taken = s_pt; i_pred_pc = s_ppc;
    i_op0_lt_op1 = (s_op0 < s_op1);
    i_sign_op0_lt_op1 = ($signed(s_op0) < $signed(s_op1));
    if (!stall) begin
      si = 32'($signed(s_ii));
      sb = 32'($signed(s_ib)) * 2;
      ctl = 1; tk = 0; tgt = s_pc + 4;
      if (s_jalr) begin
        tk = 1; tgt = (s_op0 + si) & 32'hFFFF_FFFE;
      end else if (s_jal) begin
        tk = 1; tgt = s_ppc;
      end else if (s_b) begin
        case (s_f3)
          3'd0: tk = (s_op0 == s_op1);
          3'd1: tk = (s_op0 != s_op1);
          3'd4: tk = ($signed(s_op0) < $signed(s_op1));
          3'd5: tk = ($signed(s_op0) >= $signed(s_op1));
          3'd6: tk = (s_op0 < s_op1);
          3'd7: tk = (s_op0 >= s_op1);
          default: ctl = 0;
        endcase
        if (tk) tgt = s_pc + sb;
      end else begin
        ctl = 0;
      end
      remaining = pending_redirect ? FLUSH_SHADOW : wrong_path_left;
      ok = !s_bubble && ctl && (remaining == 0);
      wrong_path_left = (remaining > 0) ? remaining - 1 : 0;
      mis = (tk != s_pt) || (tk && (tgt != s_ppc));
      pending_redirect = ok && mis;
      if (ok) begin
        r.pc = s_pc; r.target = tgt; r.nxt = s_pc + 4; r.taken = tk;
        r.flush = mis; r.jump = s_jal || s_jalr;
        exp_q.push_back(r);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    set_slot(1, 0, 0, 0, 3'd0, 12'd0, 12'd0, 32'h0, 32'h0, 32'h0, 0, 32'h0);
    for (int k = 0; k < n; k++) issue(0, 0);
  endtask

  task automatic enter_reset(input bit stall);
    aresetn = 1'b0; i_stall = stall; i_cnt_clr = 1'b0;
    exp_q.delete();
    wrong_path_left = 0; pending_redirect = 0;
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_flush"}, 32'(o_flush), 32'd0);
    chk({tag, "_bubble"}, 32'(o_bubble), 32'd1);
    chk({tag, "_taken"}, 32'(o_branch_taken), 32'd0);
    chk({tag, "_branch_pc"}, o_branch_pc, PC_INIT);
    chk({tag, "_nxt_pc"}, o_nxt_instr_pc, PC_INIT);
    chk({tag, "_upd_valid"}, 32'(o_bp_upd_valid), 32'd0);
    chk({tag, "_upd_pc"}, o_bp_upd_pc, PC_INIT);
    chk({tag, "_cnt_br"}, 32'(o_cnt_branches), 32'd0);
    chk({tag, "_cnt_mis"}, 32'(o_cnt_mispredicts), 32'd0);
  endtask

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 4))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: counters are checked every cycle, retire records on every update strobe.
  int exp_br = 0;
  int exp_mis = 0;
  initial begin
    exp_t r;
    bit retired, rflush;
    forever begin
      @(negedge clk);
      chk("cnt_branches", 32'(o_cnt_branches), 32'(exp_br));
      chk("cnt_mispredicts", 32'(o_cnt_mispredicts), 32'(exp_mis));
      if (!aresetn) begin
        exp_br = 0; exp_mis = 0;
      end else begin
        retired = 0; rflush = 0;
        if (o_bp_upd_valid) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL upd_unexpected: got update pc 0x%08h expected none at %0t", o_bp_upd_pc, $time);
          end else begin
            r = exp_q.pop_front();
            retired = 1; rflush = r.flush;
            $display("retire pc=0x%08h taken=%0d target=0x%08h flush=%0d", r.pc, r.taken, r.target, r.flush);
            chk("upd_pc", o_bp_upd_pc, r.pc);
            chk("upd_taken", 32'(o_bp_upd_taken), 32'(r.taken));
            chk("upd_target", o_bp_upd_target, r.target);
            chk("branch_pc", o_branch_pc, r.target);
            chk("branch_taken", 32'(o_branch_taken), 32'(r.taken));
            chk("nxt_instr_pc", o_nxt_instr_pc, r.nxt);
            chk("flush", 32'(o_flush), 32'(r.flush));
            chk("bubble", 32'(o_bubble), 32'(!r.jump));
          end
        end else if (o_flush && !i_stall) begin
          n_cmp++; n_fail++;
          $display("FAIL flush_without_update: got flush=1 expected 0 at %0t", $time);
        end
        if (i_cnt_clr) begin
          exp_br = 0; exp_mis = 0;
        end else if (retired) begin
          if (exp_br < CNT_MAX) exp_br++;
          if (rflush && exp_mis < CNT_MAX) exp_mis++;
        end
      end
    end
  end

  initial begin
    bit [3:0] flush_pat, upd_pat;
    int flush_cycles;
    aresetn = 1'b0;
    idle(0);
    issue(0, 0);
    enter_reset(0);
    chk_reset_outputs("reset");
    aresetn = 1'b1;

    // BEQ equal operands, predicted not-taken: redirect to 0x110.
    set_slot(0, 0, 0, 1, 3'd0, 12'd0, 12'h008, 32'h100, 32'd5, 32'd5, 0, 32'h104);
    issue(0, 0);
    chk("t1_flush", 32'(o_flush), 32'd1);
    chk("t1_branch_pc", o_branch_pc, 32'h110);
    idle(1);
    chk("t1_cnt_mis", 32'(o_cnt_mispredicts), 32'd1);
    idle(2);

    // JALR target (0x2001+2)&~1 = 0x2002: first prediction right, second wrong.
    set_slot(0, 0, 1, 0, 3'd0, 12'h002, 12'd0, 32'h400, 32'h2001, 32'h0, 1, 32'h2002);
    issue(0, 0);
    chk("t2_noflush", 32'(o_flush), 32'd0);
    set_slot(0, 0, 1, 0, 3'd0, 12'h002, 12'd0, 32'h404, 32'h2001, 32'h0, 1, 32'h3000);
    issue(0, 0);
    chk("t2_flush", 32'(o_flush), 32'd1);
    chk("t2_branch_pc", o_branch_pc, 32'h2002);
    chk("t2_bubble", 32'(o_bubble), 32'd0);
    idle(3);

    // Four consecutive mispredicted taken branches: slots 2-3 fall in the shadow.
    for (int k = 0; k < 4; k++) begin
      set_slot(0, 0, 0, 1, 3'd0, 12'd0, 12'h010, 32'h300 + 32'(4 * k), 32'd7, 32'd7, 0, 32'h0);
      issue(0, 0);
      flush_pat[3-k] = o_flush;
      upd_pat[3-k] = o_bp_upd_valid;
    end
    chk("t3_flush_pattern", 32'(flush_pat), 32'b1001);
    chk("t3_upd_pattern", 32'(upd_pat), 32'b1001);
    idle(3);

    // Flush held through a 4-cycle stall, counted once.
    idle(0);
    issue(0, 1);
    set_slot(0, 1, 0, 0, 3'd0, 12'd0, 12'd0, 32'h500, 32'h0, 32'h0, 0, 32'h800);
    issue(0, 0);
    flush_cycles = o_flush ? 1 : 0;
    for (int k = 0; k < 4; k++) begin
      issue(1, 0);
      if (o_flush) flush_cycles++;
    end
    idle(2);
    chk("t4_flush_cycles", 32'(flush_cycles), 32'd5);
    chk("t4_cnt_br", 32'(o_cnt_branches), 32'd1);
    chk("t4_cnt_mis", 32'(o_cnt_mispredicts), 32'd1);
    idle(2);

    // 20 correctly predicted branches saturate a 4-bit counter; clear beats retire.
    idle(0);
    issue(0, 1);
    for (int k = 0; k < 20; k++) begin
      set_slot(0, 0, 0, 1, 3'd1, 12'd0, 12'h020, 32'h600 + 32'(4 * k), 32'd3, 32'd3, 0, 32'h0);
      issue(0, 0);
    end
    idle(1);
    chk("t5_cnt_sat", 32'(o_cnt_branches), 32'd15);
    set_slot(0, 0, 0, 1, 3'd1, 12'd0, 12'h020, 32'h700, 32'd3, 32'd3, 0, 32'h0);
    issue(0, 0);
    idle(0);
    issue(0, 1);
    chk("t5_clr_vs_retire", 32'(o_cnt_branches), 32'd0);
    idle(2);

    // Illegal funct3 and a bubbled JAL produce nothing.
    set_slot(0, 0, 0, 1, 3'd2, 12'd0, 12'h040, 32'h900, 32'd1, 32'd1, 1, 32'h0);
    issue(0, 0);
    chk("t6_illegal_flush", 32'(o_flush), 32'd0);
    chk("t6_illegal_bubble", 32'(o_bubble), 32'd1);
    chk("t6_illegal_upd", 32'(o_bp_upd_valid), 32'd0);
    set_slot(1, 1, 0, 0, 3'd0, 12'd0, 12'd0, 32'h904, 32'd0, 32'd0, 0, 32'hA00);
    issue(0, 0);
    chk("t6_bubble_flush", 32'(o_flush), 32'd0);
    chk("t6_bubble_bubble", 32'(o_bubble), 32'd1);
    chk("t6_bubble_upd", 32'(o_bp_upd_valid), 32'd0);

    // Reset during a stalled flush, then a mispredict must be honoured at once.
    set_slot(0, 1, 0, 0, 3'd0, 12'd0, 12'd0, 32'hB00, 32'd0, 32'd0, 0, 32'hC00);
    issue(0, 0);
    issue(1, 0);
    chk("t6_stalled_flush", 32'(o_flush), 32'd1);
    enter_reset(1);
    chk_reset_outputs("t6_reset");
    aresetn = 1'b1;
    set_slot(0, 1, 0, 0, 3'd0, 12'd0, 12'd0, 32'hB10, 32'd0, 32'd0, 0, 32'hD00);
    issue(0, 0);
    chk("t6_post_reset_flush", 32'(o_flush), 32'd1);
    idle(3);

    // Randomised traffic with stalls and occasional counter clears.
    for (int k = 0; k < 400; k++) begin
      bit stall, clr;
      logic [31:0] pc, op0, op1, ppc;
      logic [11:0] ii, ib;
      stall = ($urandom_range(0, 4) == 0);
      clr = !stall && ($urandom_range(0, 19) == 0);
      pc = $urandom & 32'hFFFF_FFFC;
      op0 = pick_op();
      op1 = ($urandom_range(0, 2) == 0) ? op0 : pick_op();
      ii = 12'($urandom);
      ib = 12'($urandom);
      case ($urandom_range(0, 3))
        0: ppc = pc + 4;
        1: ppc = pc + 32'($signed(ib)) * 2;
        2: ppc = (op0 + 32'($signed(ii))) & 32'hFFFF_FFFE;
        default: ppc = $urandom;
      endcase
      set_slot($urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 1) == 1, 3'($urandom), ii, ib, pc, op0, op1,
               $urandom_range(0, 1) == 1, ppc);
      issue(stall, clr);
    end

    idle(4);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
